// File: rtl/ovl_never_unknown_multi.sv
// Multi-channel never-unknown checker: flags X/Z on any unmasked channel, counts
// error cycles up to err_limit then halts, and tracks per-cycle value-change coverage.
module ovl_never_unknown_multi #(
  parameter int    severity_level = 1,
  parameter int    num_channels   = 4,
  parameter int    width          = 8,
  parameter int    property_type  = 0,
  parameter string msg            = "VIOLATION",
  parameter int    coverage_level = 2,
  parameter int    clock_edge     = 1,
  parameter int    gating_type    = 1,
  parameter int    err_limit      = 4,
  parameter int    cnt_width      = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [num_channels*width-1:0] test_expr,
  input  logic [num_channels-1:0]       chan_mask,
  input  logic                          clear,
  output logic [2:0]                    fire,
  output logic [num_channels-1:0]       err_chan,
  output logic [cnt_width-1:0]          err_count,
  output logic [cnt_width-1:0]          cov_count,
  output logic                          halted
);

  localparam logic [cnt_width-1:0] LIMIT   = cnt_width'(err_limit);
  localparam logic [cnt_width-1:0] CNT_MAX = '1;
  localparam bit                   COV_EN  = ((coverage_level / 2) % 2) != 0;

  typedef enum logic [1:0] {ARMED, ERRORED, HALTED} state_e;

  logic ck;
  assign ck = (clock_edge != 0) ? clock : ~clock;

  state_e                        state_q, state_d;
  logic [num_channels*width-1:0] prev_q, prev_d;
  logic                          prev_vld_q, prev_vld_d;
  logic [2:0]                    fire_q, fire_d;
  logic [num_channels-1:0]       err_chan_q, err_chan_d;
  logic [num_channels-1:0]       rpt_mask_q, rpt_mask_d;
  logic [cnt_width-1:0]          err_count_q, err_count_d;
  logic [cnt_width-1:0]          cov_count_q, cov_count_d;
  logic [cnt_width-1:0]          err_count_inc;
  logic [num_channels-1:0]       unk, chg;
  logic                          xin, rst, active, err_cyc;

  // Per-channel unknown and change detection; masked channels never contribute.
  for (genvar k = 0; k < num_channels; k++) begin : g_lane
    logic [width-1:0] cur, prv;
    assign cur    = test_expr[k*width +: width];
    assign prv    = prev_q[k*width +: width];
    assign unk[k] = !chan_mask[k] && $isunknown(cur);
    assign chg[k] = !chan_mask[k] && prev_vld_q && (cur !== prv);
  end

  // An unknown control sample is ignored entirely, but a known-low enable under
  // gating_type 2 behaves as reset even then.
  always_comb begin
    xin           = $isunknown(enable) || $isunknown(clear);
    rst           = !reset || (gating_type == 2 && !$isunknown(enable) && !enable);
    active        = !rst && !xin && (gating_type == 0 || enable);
    err_cyc       = active && !clear && (|unk) && (state_q != HALTED);
    err_count_inc = (err_count_q >= LIMIT) ? LIMIT : err_count_q + 1'b1;
  end

  always_ff @(posedge ck) begin
    if (!reset) state_q <= ARMED;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (rst)
      state_d = ARMED;
    else if (active && clear)
      state_d = ARMED;
    else if (err_cyc)
      state_d = (err_count_inc == LIMIT) ? HALTED : ERRORED;
  end

  always_comb begin
    prev_d      = prev_q;
    prev_vld_d  = prev_vld_q;
    err_chan_d  = err_chan_q;
    err_count_d = err_count_q;
    cov_count_d = cov_count_q;
    rpt_mask_d  = '0;
    fire_d      = '0;
    if (rst) begin
      prev_vld_d  = 1'b0;
      err_chan_d  = '0;
      err_count_d = '0;
      cov_count_d = '0;
    end else begin
      fire_d[1] = xin;
      if (active) begin
        prev_d     = test_expr;
        prev_vld_d = 1'b1;
        if (COV_EN && (|chg)) begin
          fire_d[2] = 1'b1;
          if (cov_count_q != CNT_MAX) cov_count_d = cov_count_q + 1'b1;
        end
        if (clear) begin
          err_chan_d  = '0;
          err_count_d = '0;
        end else if (err_cyc) begin
          err_chan_d  = err_chan_q | unk;
          err_count_d = err_count_inc;
          fire_d[0]   = (property_type != 2);
          rpt_mask_d  = unk;
        end
      end
    end
  end

  always_ff @(posedge ck) begin
    if (!reset) begin
      prev_q      <= '0;
      prev_vld_q  <= 1'b0;
      fire_q      <= '0;
      err_chan_q  <= '0;
      rpt_mask_q  <= '0;
      err_count_q <= '0;
      cov_count_q <= '0;
    end else begin
      prev_q      <= prev_d;
      prev_vld_q  <= prev_vld_d;
      fire_q      <= fire_d;
      err_chan_q  <= err_chan_d;
      rpt_mask_q  <= rpt_mask_d;
      err_count_q <= err_count_d;
      cov_count_q <= cov_count_d;
    end
  end

  always_comb begin
    fire      = fire_q;
    err_chan  = err_chan_q;
    err_count = err_count_q;
    cov_count = cov_count_q;
    halted    = (state_q == HALTED);
  end

  // Report while the fire pulse is visible; rpt_mask_q holds the offending channels.
  always_ff @(posedge ck) begin
    if (fire_q[0]) begin
      case (severity_level)
        0:       $fatal(1, "%s: unknown on channels %b", msg, rpt_mask_q);
        1:       $error("%s: unknown on channels %b", msg, rpt_mask_q);
        2:       $warning("%s: unknown on channels %b", msg, rpt_mask_q);
        default: $info("%s: unknown on channels %b", msg, rpt_mask_q);
      endcase
    end
  end

endmodule

// File: tb/tb_ovl_never_unknown_multi.sv
// Directed + random bench for ovl_never_unknown_multi; two instances differ only in
// gating_type (1 and 2) and both are checked against a behavioural model every cycle.
module tb_ovl_never_unknown_multi;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset, enable, clear;
  logic [31:0] test_expr;
  logic [3:0]  chan_mask;

  logic [2:0] fire1, fire2;
  logic [3:0] err_chan1, err_chan2;
  logic [7:0] err_count1, err_count2, cov_count1, cov_count2;
  logic       halted1, halted2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ovl_never_unknown_multi #(.severity_level(3), .gating_type(1)) dut (
    .clock(clk), .reset(reset), .enable(enable), .test_expr(test_expr),
    .chan_mask(chan_mask), .clear(clear), .fire(fire1), .err_chan(err_chan1),
    .err_count(err_count1), .cov_count(cov_count1), .halted(halted1));

  ovl_never_unknown_multi #(.severity_level(3), .gating_type(2)) dut_g2 (
    .clock(clk), .reset(reset), .enable(enable), .test_expr(test_expr),
    .chan_mask(chan_mask), .clear(clear), .fire(fire2), .err_chan(err_chan2),
    .err_count(err_count2), .cov_count(cov_count2), .halted(halted2));

  // Model state: st 0=armed 1=errored 2=halted
  typedef struct {
    int          st;
    int          ecount;
    logic [3:0]  echan;
    int          ccount;
    bit          pvalid;
    logic [31:0] prev;
    logic [2:0]  fire;
  } mdl_t;

  mdl_t m1, m2;

  function automatic mdl_t mreset();
    mdl_t r;
    r.st = 0; r.ecount = 0; r.echan = '0; r.ccount = 0;
    r.pvalid = 1'b0; r.prev = '0; r.fire = '0;
    return r;
  endfunction

  // One active edge of the checker, from the rules: reset/gating, X controls,
  // change coverage, clear, one count per error cycle, halting at LIMIT.
  function automatic mdl_t mstep(mdl_t m, int gt);
    mdl_t       n;
    logic [3:0] unkn;
    bit         anychg;
    n      = m;
    n.fire = '0;
    if (reset === 1'b0 || (gt == 2 && enable === 1'b0)) return mreset();
    if ($isunknown(enable) || $isunknown(clear)) begin
      n.fire[1] = 1'b1;
      return n;
    end
    if (gt != 0 && enable !== 1'b1) return n;
    anychg = 1'b0;
    for (int k = 0; k < 4; k++) begin
      unkn[k] = !chan_mask[k] && $isunknown(test_expr[k*8 +: 8]);
      if (m.pvalid && !chan_mask[k] && (test_expr[k*8 +: 8] !== m.prev[k*8 +: 8]))
        anychg = 1'b1;
    end
    n.prev   = test_expr;
    n.pvalid = 1'b1;
    if (anychg) begin
      n.fire[2] = 1'b1;
      if (n.ccount < 255) n.ccount++;
    end
    if (clear) begin
      n.st = 0; n.ecount = 0; n.echan = '0;
    end else if (unkn != 4'b0 && m.st != 2) begin
      n.ecount  = m.ecount + 1;
      n.echan   = m.echan | unkn;
      n.fire[0] = 1'b1;
      n.st      = (n.ecount >= LIMIT) ? 2 : 1;
    end
    return n;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_model();
    chk("g1.fire",   64'(fire1),      64'(m1.fire));
    chk("g1.echan",  64'(err_chan1),  64'(m1.echan));
    chk("g1.ecount", 64'(err_count1), 64'(m1.ecount));
    chk("g1.ccount", 64'(cov_count1), 64'(m1.ccount));
    chk("g1.halted", 64'(halted1),    64'(m1.st == 2));
    chk("g2.fire",   64'(fire2),      64'(m2.fire));
    chk("g2.echan",  64'(err_chan2),  64'(m2.echan));
    chk("g2.ecount", 64'(err_count2), 64'(m2.ecount));
    chk("g2.ccount", 64'(cov_count2), 64'(m2.ccount));
    chk("g2.halted", 64'(halted2),    64'(m2.st == 2));
  endtask

  task automatic step();
    @(posedge clk);
    m1 = mstep(m1, 1);
    m2 = mstep(m2, 2);
    #1;
    chk_model();
  endtask

  initial begin
    logic [7:0] xv;
    int         pulses;
    xv        = 8'bxxxx_xxxx;
    m1        = mreset();
    m2        = mreset();
    reset     = 1'b0;
    enable    = 1'b1;
    clear     = 1'b0;
    chan_mask = 4'b0;
    test_expr = 32'h0;
    step();
    step();
    chk("rst.fire",   64'(fire1),      64'd0);
    chk("rst.echan",  64'(err_chan1),  64'd0);
    chk("rst.ecount", 64'(err_count1), 64'd0);
    chk("rst.ccount", 64'(cov_count1), 64'd0);
    chk("rst.halted", 64'(halted1),    64'd0);

    reset = 1'b1;
    step();
    step();

    // Single-cycle X nibble on channel 2
    test_expr[23:16] = {4'h1, xv[3:0]};
    step();
    test_expr = 32'h0;
    step();

    // Channels 0 and 3 unknown for six consecutive cycles, then clear with X present
    test_expr[7:0]   = xv;
    test_expr[31:24] = xv;
    for (int i = 0; i < 6; i++) step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    test_expr = 32'h0;
    step();

    // Masked channel 1, then unmasked
    chan_mask = 4'b0010;
    test_expr[15:8] = xv;
    step();
    step();
    chan_mask = 4'b0000;
    step();
    test_expr = 32'h0;
    step();

    // enable low: gating 1 holds, gating 2 returns to reset values
    enable = 1'b0;
    test_expr[7:0] = xv;
    step();
    step();
    chk("g2off.fire",   64'(fire2),      64'd0);
    chk("g2off.echan",  64'(err_chan2),  64'd0);
    chk("g2off.ecount", 64'(err_count2), 64'd0);
    chk("g2off.ccount", 64'(cov_count2), 64'd0);
    chk("g2off.halted", 64'(halted2),    64'd0);
    enable = 1'b1;
    test_expr = 32'h0;
    step();

    // Fresh reset, then channel 0 toggling for five active cycles
    reset = 1'b0;
    step();
    reset  = 1'b1;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      test_expr = (i % 2 == 0) ? 32'h0000_0000 : 32'h0000_00FF;
      step();
      if (fire1[2] === 1'b1) pulses++;
    end
    chk("tog.pulses", 64'(pulses),     64'd4);
    chk("tog.ccount", 64'(cov_count1), 64'd4);
    chk("tog.g2cnt",  64'(cov_count2), 64'd4);
    enable = 1'bx;
    step();
    enable = 1'b1;
    step();

    // Randomised phase
    for (int i = 0; i < 300; i++) begin
      reset     = ($urandom_range(39) != 0);
      enable    = ($urandom_range(7) != 0);
      clear     = ($urandom_range(19) == 0);
      chan_mask = 4'($urandom_range(15));
      for (int k = 0; k < 4; k++) begin
        if ($urandom_range(5) == 0)      test_expr[k*8 +: 8] = xv;
        else if ($urandom_range(2) == 0) test_expr[k*8 +: 8] = 8'($urandom_range(255));
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
